// File: rtl/ercm8_mac_acc.sv
// ercm8_mac_acc: saturating burst accumulator for approximate 16-bit products.
// Sums a burst of beats (closed by in_last or after MAX_TERMS beats) into an
// ACC_W-bit result that is held until the consumer takes it.
// Optional feature macro: ERCM_ERR_TRACK_EN adds operand inputs and err_o,
// the accumulated |a*b - in_prod| over the burst.
module ercm8_mac_acc #(
  parameter int ACC_W     = 24,
  parameter int MAX_TERMS = 256,
  localparam int CNT_W    = $clog2(MAX_TERMS) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [15:0]      in_prod,
  input  logic             in_last,
`ifdef ERCM_ERR_TRACK_EN
  input  logic [7:0]       dat_in_a,
  input  logic [7:0]       dat_in_b,
  output logic [ACC_W-1:0] err_o,
`endif
  output logic [ACC_W-1:0] acc_o,
  output logic             acc_vld,
  input  logic             acc_rdy,
  output logic             acc_ovf,
  output logic [CNT_W-1:0] acc_cnt
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);

  state_t           state, state_n;
  logic [ACC_W-1:0] acc, acc_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             ovf, ovf_n;
  logic             beat;
  logic [ACC_W:0]   acc_sum;

  // Unsigned add of a 16-bit term; top bit is the carry, and on carry the
  // result is forced to all ones so a saturated sum stays saturated.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] base,
                                             input logic [15:0]      term);
    logic [ACC_W:0] s;
    s = {1'b0, base} + (ACC_W+1)'(term);
    return s[ACC_W] ? {1'b1, {ACC_W{1'b1}}} : s;
  endfunction

`ifdef ERCM_ERR_TRACK_EN
  logic [ACC_W-1:0] err, err_n;
  logic [15:0]      exact;
  logic [15:0]      diff;
  logic [ACC_W:0]   err_sum;

  // Absolute distance between the exact product and the approximate one.
  always_comb begin
    exact   = 16'(dat_in_a * dat_in_b);
    diff    = (exact >= in_prod) ? (exact - in_prod) : (in_prod - exact);
    err_sum = sat_add(err, diff);
  end

  assign err_o = err;
`endif

  // HOLD refuses beats; reset also forces the handshake low.
  assign in_rdy  = ~rst & (state != HOLD);
  assign beat    = in_vld & in_rdy;
  assign acc_sum = sat_add(acc, in_prod);

  assign acc_o   = acc;
  assign acc_cnt = cnt;
  assign acc_ovf = ovf;
  assign acc_vld = (state == HOLD);

  // Next-state and datapath update for the IDLE/ACCUM/HOLD burst machine.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    ovf_n   = ovf;
`ifdef ERCM_ERR_TRACK_EN
    err_n   = err;
`endif
    unique case (state)
      IDLE: begin
        if (beat) begin
          acc_n   = ACC_W'(in_prod);
          cnt_n   = CNT_W'(1);
          ovf_n   = 1'b0;
`ifdef ERCM_ERR_TRACK_EN
          err_n   = ACC_W'(diff);
`endif
          state_n = (in_last || MAX_TERMS == 1) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (beat) begin
          acc_n   = acc_sum[ACC_W-1:0];
          ovf_n   = ovf | acc_sum[ACC_W];
          cnt_n   = cnt + CNT_W'(1);
`ifdef ERCM_ERR_TRACK_EN
          err_n   = err_sum[ACC_W-1:0];
`endif
          state_n = (in_last || cnt_n == MAX_CNT) ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        if (acc_rdy) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State and result registers; reset discards any open burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
`ifdef ERCM_ERR_TRACK_EN
      err   <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so all registers update together from pre-edge values.
      state <= state_n;
      acc   <= acc_n;
      cnt   <= cnt_n;
      ovf   <= ovf_n;
`ifdef ERCM_ERR_TRACK_EN
      err   <= err_n;
`endif
    end
  end

endmodule

// File: tb/tb_ercm8_mac_acc.sv
// Directed bench for ercm8_mac_acc: a table of bursts on a 24-bit/256-term
// instance, plus hand sequences for reset, hold, saturation (16-bit, 4-term
// instance) and the MAX_TERMS boundary. Handles ERCM_ERR_TRACK_EN builds.
module tb_ercm8_mac_acc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  // 24-bit, 256-term instance
  logic        in_vld, in_rdy, in_last, acc_vld, acc_rdy, acc_ovf;
  logic [15:0] in_prod;
  logic [23:0] acc_o;
  logic [8:0]  acc_cnt;
  logic [7:0]  a, b;
  // 16-bit, 4-term instance
  logic        s_vld, s_rdy, s_last, s_acc_vld, s_acc_rdy, s_ovf;
  logic [15:0] s_prod;
  logic [15:0] s_acc;
  logic [2:0]  s_cnt;
  logic [7:0]  s_a, s_b;
`ifdef ERCM_ERR_TRACK_EN
  logic [23:0] err_o;
  logic [15:0] s_err;
`endif

  ercm8_mac_acc #(.ACC_W(24), .MAX_TERMS(256)) u_dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy),
    .in_prod(in_prod), .in_last(in_last),
`ifdef ERCM_ERR_TRACK_EN
    .dat_in_a(a), .dat_in_b(b), .err_o(err_o),
`endif
    .acc_o(acc_o), .acc_vld(acc_vld), .acc_rdy(acc_rdy),
    .acc_ovf(acc_ovf), .acc_cnt(acc_cnt)
  );

  ercm8_mac_acc #(.ACC_W(16), .MAX_TERMS(4)) u_dut16 (
    .clk(clk), .rst(rst), .in_vld(s_vld), .in_rdy(s_rdy),
    .in_prod(s_prod), .in_last(s_last),
`ifdef ERCM_ERR_TRACK_EN
    .dat_in_a(s_a), .dat_in_b(s_b), .err_o(s_err),
`endif
    .acc_o(s_acc), .acc_vld(s_acc_vld), .acc_rdy(s_acc_rdy),
    .acc_ovf(s_ovf), .acc_cnt(s_cnt)
  );

  typedef struct packed {
    logic [2:0]       n;
    logic [3:0][15:0] prod;
    logic [3:0][7:0]  va;
    logic [3:0][7:0]  vb;
    logic [23:0]      exp_acc;
    logic [8:0]       exp_cnt;
    logic             exp_ovf;
    logic [23:0]      exp_err;
  } vec_t;

  vec_t vecs[4];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One accepted beat on the main instance; inputs get junk afterwards.
  task automatic beat(input logic [15:0] p, input logic l, input logic [7:0] va, input logic [7:0] vb);
    check("in_rdy before beat", 32'(in_rdy), 32'd1);
    in_vld = 1'b1; in_prod = p; in_last = l; a = va; b = vb;
    @(posedge clk); #1;
    in_vld = 1'b0; in_last = 1'b1; in_prod = 16'hDEAD; a = 8'h5A; b = 8'hA5;
  endtask

  task automatic handshake(input string name);
    in_last = 1'b0;
    acc_rdy = 1'b1;
    @(posedge clk); #1;
    acc_rdy = 1'b0;
    check({name, " acc_vld after accept"}, 32'(acc_vld), 32'd0);
    check({name, " in_rdy after accept"}, 32'(in_rdy), 32'd1);
  endtask

  task automatic s_beat(input logic [15:0] p, input logic l);
    s_vld = 1'b1; s_prod = p; s_last = l;
    @(posedge clk); #1;
    s_vld = 1'b0; s_last = 1'b0; s_prod = 16'hBEEF;
  endtask

  task automatic s_handshake();
    s_acc_rdy = 1'b1;
    @(posedge clk); #1;
    s_acc_rdy = 1'b0;
    check("s acc_vld after accept", 32'(s_acc_vld), 32'd0);
  endtask

  function automatic vec_t mk(input logic [2:0] n, input logic [63:0] p,
                              input logic [31:0] va, input logic [31:0] vb,
                              input logic [23:0] ea, input logic [8:0] ec,
                              input logic eo, input logic [23:0] ee);
    vec_t v;
    v.n = n; v.prod = p; v.va = va; v.vb = vb;
    v.exp_acc = ea; v.exp_cnt = ec; v.exp_ovf = eo; v.exp_err = ee;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 4*4=16 (err 0), 5*6=30 vs 32 (err 2), 7*7=49 vs 48 (err 1)
    vecs[0] = mk(3'd3, {16'h0, 16'h0030, 16'h0020, 16'h0010},
                 {8'h0, 8'd7, 8'd5, 8'd4}, {8'h0, 8'd7, 8'd6, 8'd4},
                 24'h000060, 9'd3, 1'b0, 24'd3);
    // 0xFF*0xFF = 0xFE01, |0xFE01-0xFC00| = 0x201
    vecs[1] = mk(3'd1, {48'h0, 16'hFC00}, {24'h0, 8'hFF}, {24'h0, 8'hFF},
                 24'h00FC00, 9'd1, 1'b0, 24'h000201);
    // 4 x 0xFFFF = 0x3FFFC; err 4 x 0x1FE = 0x7F8
    vecs[2] = mk(3'd4, {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF},
                 32'hFFFFFFFF, 32'hFFFFFFFF, 24'h03FFFC, 9'd4, 1'b0, 24'h0007F8);
    // 0x12*0x10 = 0x120 vs 0x1234 -> 0x1114; 1*1 vs 1 -> 0
    vecs[3] = mk(3'd2, {32'h0, 16'h0001, 16'h1234}, {16'h0, 8'h01, 8'h12},
                 {16'h0, 8'h01, 8'h10}, 24'h001235, 9'd2, 1'b0, 24'h001114);

    in_vld = 0; in_prod = 0; in_last = 0; acc_rdy = 0; a = 0; b = 0;
    s_vld = 0; s_prod = 0; s_last = 0; s_acc_rdy = 0; s_a = 0; s_b = 0;

    // Reset state
    rst = 1'b1;
    #3;
    check("reset acc_o", 32'(acc_o), 32'd0);
    check("reset acc_vld", 32'(acc_vld), 32'd0);
    check("reset acc_ovf", 32'(acc_ovf), 32'd0);
    check("reset acc_cnt", 32'(acc_cnt), 32'd0);
    check("reset in_rdy", 32'(in_rdy), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("in_rdy after reset", 32'(in_rdy), 32'd1);

    // Table-driven bursts, one stall cycle with junk after the first beat
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < int'(vecs[i].n); j++) begin
        beat(vecs[i].prod[j], j == int'(vecs[i].n) - 1, vecs[i].va[j], vecs[i].vb[j]);
        if (j < int'(vecs[i].n) - 1) begin
          check($sformatf("vec%0d acc_vld mid-burst", i), 32'(acc_vld), 32'd0);
          if (j == 0) begin
            @(posedge clk); #1;
          end
        end
      end
      check($sformatf("vec%0d acc_vld", i), 32'(acc_vld), 32'd1);
      check($sformatf("vec%0d acc_o", i), 32'(acc_o), 32'(vecs[i].exp_acc));
      check($sformatf("vec%0d acc_cnt", i), 32'(acc_cnt), 32'(vecs[i].exp_cnt));
      check($sformatf("vec%0d acc_ovf", i), 32'(acc_ovf), 32'(vecs[i].exp_ovf));
`ifdef ERCM_ERR_TRACK_EN
      check($sformatf("vec%0d err_o", i), 32'(err_o), 32'(vecs[i].exp_err));
`endif
      if (i == 0) begin
        // Hold with acc_rdy low while a beat is offered and must be refused
        in_vld = 1'b1; in_prod = 16'h7777; in_last = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(posedge clk); #1;
          check($sformatf("hold%0d acc_o", k), 32'(acc_o), 32'h60);
          check($sformatf("hold%0d in_rdy", k), 32'(in_rdy), 32'd0);
          check($sformatf("hold%0d acc_vld", k), 32'(acc_vld), 32'd1);
        end
        in_vld = 1'b0;
      end
      handshake($sformatf("vec%0d", i));
      check($sformatf("vec%0d acc_o kept", i), 32'(acc_o), 32'(vecs[i].exp_acc));
    end

    // Saturation on the 16-bit instance
    s_beat(16'hFFF0, 1'b0);
    s_beat(16'h0020, 1'b1);
    check("sat acc_vld", 32'(s_acc_vld), 32'd1);
    check("sat acc_o", 32'(s_acc), 32'hFFFF);
    check("sat acc_ovf", 32'(s_ovf), 32'd1);
    check("sat acc_cnt", 32'(s_cnt), 32'd2);
`ifdef ERCM_ERR_TRACK_EN
    check("sat err_o", 32'(s_err), 32'hFFFF);
`endif
    s_handshake();
    // Saturated value stays at all ones for the rest of the burst
    s_beat(16'hFFF0, 1'b0);
    s_beat(16'h0020, 1'b0);
    s_beat(16'h0001, 1'b1);
    check("sat sticky acc_o", 32'(s_acc), 32'hFFFF);
    check("sat sticky acc_ovf", 32'(s_ovf), 32'd1);
    check("sat sticky acc_cnt", 32'(s_cnt), 32'd3);
    s_handshake();
    // Four-term limit closes the burst; ovf cleared by the new burst
    for (int k = 0; k < 4; k++) s_beat(16'h0001, 1'b0);
    check("limit4 acc_vld", 32'(s_acc_vld), 32'd1);
    check("limit4 in_rdy", 32'(s_rdy), 32'd0);
    check("limit4 acc_o", 32'(s_acc), 32'd4);
    check("limit4 acc_cnt", 32'(s_cnt), 32'd4);
    check("limit4 acc_ovf", 32'(s_ovf), 32'd0);
    s_handshake();

    // 256 beats with in_last on beat 256: exactly one result
    for (int k = 0; k < 256; k++) beat(16'h0001, k == 255, 8'h01, 8'h01);
    check("last256 acc_vld", 32'(acc_vld), 32'd1);
    check("last256 acc_o", 32'(acc_o), 32'd256);
    check("last256 acc_cnt", 32'(acc_cnt), 32'd256);
    handshake("last256");
    @(posedge clk); #1;
    check("last256 no second result", 32'(acc_vld), 32'd0);

    // 256 beats without in_last: limit closes it, beat 257 starts a new burst
    for (int k = 0; k < 256; k++) beat(16'h0001, 1'b0, 8'h00, 8'h00);
    check("max256 acc_vld", 32'(acc_vld), 32'd1);
    check("max256 acc_o", 32'(acc_o), 32'd256);
    check("max256 acc_cnt", 32'(acc_cnt), 32'd256);
`ifdef ERCM_ERR_TRACK_EN
    check("max256 err_o", 32'(err_o), 32'd256);
`endif
    handshake("max256");
    beat(16'h0005, 1'b1, 8'h00, 8'h00);
    check("beat257 acc_o", 32'(acc_o), 32'd5);
    check("beat257 acc_cnt", 32'(acc_cnt), 32'd1);
    handshake("beat257");

    // Reset during an open burst discards it
    beat(16'h0100, 1'b0, 8'h03, 8'h03);
    beat(16'h0200, 1'b0, 8'h03, 8'h03);
    #2 rst = 1'b1;
    #1;
    check("midrst acc_o", 32'(acc_o), 32'd0);
    check("midrst acc_cnt", 32'(acc_cnt), 32'd0);
    check("midrst in_rdy", 32'(in_rdy), 32'd0);
    check("midrst acc_vld", 32'(acc_vld), 32'd0);
`ifdef ERCM_ERR_TRACK_EN
    check("midrst err_o", 32'(err_o), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    beat(16'h0007, 1'b1, 8'h00, 8'h00);
    check("postrst acc_vld", 32'(acc_vld), 32'd1);
    check("postrst acc_o", 32'(acc_o), 32'd7);
    check("postrst acc_cnt", 32'(acc_cnt), 32'd1);
    handshake("postrst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
